adc_sar_control: RTL and testbench
==================================

# adc_sar_control

Synchronous successive-approximation controller directly downstream of the start-conversion edge detector. It consumes that stage's conversion-enable window (`ena_in`) plus a synchronous start request, drives the sample switch and the capacitive DAC code, and resolves one bit per clock from the comparator. It returns a registered result with a one-cycle valid strobe.

## Interface
- `RESOLUTION`, default 8: number of result bits N; legal range 2..16.
- `SAMPLE_CYCLES`, default 2: clock cycles the sample switch stays closed; legal range 1..255.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `ena_in`  input  1  conversion enable window from the edge-detect stage; a conversion may start or continue only while it is high.
- `start`  input  1  conversion request; level sampled on `clk`.
- `comp_in`  input  1  comparator decision; 1 means Vin >= Vdac for the current trial code.
- `sample`  output  1  sample-switch control; 1 means tracking.
- `dac_code`  output  N  trial code driven to the DAC.
- `result`  output  N  last completed conversion, held until overwritten.
- `valid`  output  1  one-cycle strobe marking a new `result`.
- `busy`  output  1  high in SAMPLE and CONVERT.

## Operation
- Reset: state IDLE; `sample`=0, `dac_code`=0, `result`=0, `valid`=0, `busy`=0; the bit index and sample counter are cleared.
- States: IDLE, SAMPLE, CONVERT. All outputs are registered.
- IDLE to SAMPLE: on an edge where `start`=1 and `ena_in`=1. `sample` goes to 1, `busy` goes to 1, and the counter loads SAMPLE_CYCLES-1.
- `start` while `ena_in`=0 is ignored.
- `start` in SAMPLE or CONVERT is ignored. There is no queuing.
- SAMPLE:
  - The counter decrements each edge.
  - On the edge where the counter is 0: `sample` goes to 0, `dac_code` goes to 1<<(N-1), the bit index goes to N-1, and the state goes to CONVERT.
- CONVERT, each edge, with i = current bit index:
  - Bit i of the working code is set to `comp_in`.
  - If i>0, bit i-1 is set and i decrements.
  - If i=0, the final code goes to `result`, `valid` goes to 1, `busy` goes to 0, `dac_code` goes to 0, and the state goes to IDLE.
  - `dac_code` always equals the working code: decided bits above i, a trial 1 at i, zeros below.
- `valid` is 1 only for the cycle after the last bit edge, then returns to 0.
- Abort: if `ena_in`=0 is sampled in SAMPLE or CONVERT, the block goes to IDLE the next state.
  - `sample`, `dac_code` and `busy` go to 0.
  - `valid` stays 0 and `result` is unchanged.
  - Abort takes priority over completing bit 0 on the same edge.
- `rst` mid-operation: behaves exactly like the reset case. `result` is cleared to 0 and no `valid` is produced.
- Widths: the bit index is ceil(log2(N)) bits and the counter is 8 bits. There is no arithmetic beyond bit set/clear, so no overflow is possible.

## Timing
Let edge k be the edge that accepts `start`.
- `sample`=1 in cycles k+1 .. k+SAMPLE_CYCLES.
- First trial code 1<<(N-1) is visible after edge k+SAMPLE_CYCLES.
- `comp_in` is sampled at edges k+SAMPLE_CYCLES+1 .. k+SAMPLE_CYCLES+N. The MSB decision comes first.
- `valid`=1 and the new `result` are visible after edge k+SAMPLE_CYCLES+N. Latency is SAMPLE_CYCLES+N edges; for the defaults this is 10.
- The earliest next `start` is accepted at edge k+SAMPLE_CYCLES+N+1, i.e. the cycle in which `valid` is high. Back-to-back throughput is one conversion per SAMPLE_CYCLES+N+1 cycles.
- `comp_in` must be settled in the cycle following each `dac_code` change. The block does not synchronize it.

## Test plan
- Nominal, N=8, SAMPLE_CYCLES=2, comparator model `comp_in` = (vin >= `dac_code`), vin=0xA5, `ena_in`=1, one-cycle `start` → `sample` high for exactly 2 cycles. `dac_code` sequence is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. `result`=0xA5 with `valid` high for 1 cycle, 10 edges after the start edge.
- Extremes:
  - vin=0x00 → `result`=0x00.
  - vin=0xFF → `result`=0xFF.
  - Back-to-back: `start` held high continuously → consecutive `valid` strobes every 11 cycles.
- Gating:
  - `start` with `ena_in`=0 → `busy` stays 0 and `sample` stays 0.
  - `ena_in` dropped after the 3rd bit edge → IDLE on the next edge, no `valid`, `result` retains its previous 0xA5.
- Ignore while busy: a second `start` pulse during CONVERT → exactly one `valid`, with the timing of the first request.
- Reset mid-CONVERT: `rst`=1 for 1 cycle → all outputs are 0 after the reset edge. A following `start` completes a normal conversion (vin=0x3C gives `result`=0x3C).
- Parameter sweep: N=2 and N=16 with SAMPLE_CYCLES=1, random vin → result equals vin and latency equals 1+N edges.

Source files
------------

// File: rtl/adc_sar_control.sv
// Successive-approximation ADC controller: sample phase, then one bit resolved per clock
// from the comparator, MSB first, with a registered result and one-cycle valid strobe.
module adc_sar_control #(
  parameter int RESOLUTION    = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_in,
  input  logic                  start,
  input  logic                  comp_in,
  output logic                  sample,
  output logic [RESOLUTION-1:0] dac_code,
  output logic [RESOLUTION-1:0] result,
  output logic                  valid,
  output logic                  busy
);

  localparam int IW = $clog2(RESOLUTION);
  localparam logic [RESOLUTION-1:0] MSB_TRIAL = {1'b1, {(RESOLUTION-1){1'b0}}};
  localparam logic [7:0]            CNT_LOAD  = 8'(SAMPLE_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_TOP   = IW'(RESOLUTION - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         idx_dec;
  logic                  sample_d, valid_d, busy_d;
  logic [RESOLUTION-1:0] dac_d, result_d, work;

  assign idx_dec = idx_q - IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sample   <= 1'b0;
      dac_code <= '0;
      result   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sample   <= sample_d;
      dac_code <= dac_d;
      result   <= result_d;
      valid    <= valid_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sample_d = sample;
    dac_d    = dac_code;
    result_d = result;
    valid_d  = 1'b0;
    busy_d   = busy;
    work     = dac_code;

    unique case (state_q)
      ST_IDLE: begin
        if (start && ena_in) begin
          state_d  = ST_SAMPLE;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = CNT_LOAD;
        end
      end

      ST_SAMPLE: begin
        if (!ena_in) begin
          state_d  = ST_IDLE;
          sample_d = 1'b0;
          dac_d    = '0;
          busy_d   = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d  = ST_CONVERT;
          sample_d = 1'b0;
          dac_d    = MSB_TRIAL;
          idx_d    = IDX_TOP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_CONVERT: begin
        // Abort is checked first so a dropped enable wins over completing bit 0.
        if (!ena_in) begin
          state_d  = ST_IDLE;
          dac_d    = '0;
          busy_d   = 1'b0;
        end else begin
          work[idx_q] = comp_in;
          if (idx_q != '0) begin
            work[idx_dec] = 1'b1;
            idx_d         = idx_dec;
            dac_d         = work;
          end else begin
            result_d = work;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            dac_d    = '0;
            state_d  = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_sar_control.sv
// Bench for adc_sar_control: stimulus pushes expected (result, valid cycle) pairs,
// per-instance monitors pop and compare on every valid strobe.
module tb_adc_sar_control;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q16[$];
  exp_t e8, e2, e16;

  // Main instance: N=8, SAMPLE_CYCLES=2
  logic       ena8 = 1'b1, start8 = 1'b0;
  logic [7:0] vin8 = '0;
  logic       comp8, sample8, valid8, busy8;
  logic [7:0] dac8, res8;
  assign comp8 = (vin8 >= dac8);

  // Sweep instances: N=2 and N=16, SAMPLE_CYCLES=1
  logic        ena2 = 1'b1, start2 = 1'b0;
  logic [1:0]  vin2 = '0;
  logic        comp2, sample2, valid2, busy2;
  logic [1:0]  dac2, res2;
  assign comp2 = (vin2 >= dac2);

  logic        ena16 = 1'b1, start16 = 1'b0;
  logic [15:0] vin16 = '0;
  logic        comp16, sample16, valid16, busy16;
  logic [15:0] dac16, res16;
  assign comp16 = (vin16 >= dac16);

  adc_sar_control #(.RESOLUTION(8), .SAMPLE_CYCLES(2)) dut8 (
    .clk(clk), .rst(rst), .ena_in(ena8), .start(start8), .comp_in(comp8),
    .sample(sample8), .dac_code(dac8), .result(res8), .valid(valid8), .busy(busy8)
  );

  adc_sar_control #(.RESOLUTION(2), .SAMPLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .ena_in(ena2), .start(start2), .comp_in(comp2),
    .sample(sample2), .dac_code(dac2), .result(res2), .valid(valid2), .busy(busy2)
  );

  adc_sar_control #(.RESOLUTION(16), .SAMPLE_CYCLES(1)) dut16 (
    .clk(clk), .rst(rst), .ena_in(ena16), .start(start16), .comp_in(comp16),
    .sample(sample16), .dac_code(dac16), .result(res16), .valid(valid16), .busy(busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: valid with no pending expectation (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (valid8) begin
      if (q8.size() == 0) unexpected("valid8");
      else begin
        e8 = q8.pop_front();
        check("result8", 32'(res8), 32'(e8.res));
        check("latency8", cyc, e8.cyc);
      end
    end
    if (valid2) begin
      if (q2.size() == 0) unexpected("valid2");
      else begin
        e2 = q2.pop_front();
        check("result2", 32'(res2), 32'(e2.res));
        check("latency2", cyc, e2.cyc);
      end
    end
    if (valid16) begin
      if (q16.size() == 0) unexpected("valid16");
      else begin
        e16 = q16.pop_front();
        check("result16", 32'(res16), 32'(e16.res));
        check("latency16", cyc, e16.cyc);
      end
    end
  end

  function automatic logic busy_sel(input int which);
    case (which)
      2:       return busy2;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  task automatic wait_idle(input int which);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy_sel(which)) return;
    end
    n_checks++;
    $display("FAIL timeout%0d: busy still high after 60 cycles", which);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Start an 8-bit conversion; after return the caller is #1 past the start-accept edge.
  task automatic launch8(input logic [7:0] v, input bit push);
    exp_t e;
    step();
    vin8 = v;
    start8 = 1'b1;
    e.res = 16'(v);
    e.cyc = cyc + 1 + 10;
    if (push) q8.push_back(e);
    step();
    start8 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] v);
    launch8(v, 1'b1);
    wait_idle(8);
  endtask

  task automatic run2(input logic [1:0] v);
    exp_t e;
    step();
    vin2 = v; start2 = 1'b1;
    e.res = 16'(v); e.cyc = cyc + 1 + 3;
    q2.push_back(e);
    step();
    start2 = 1'b0;
    wait_idle(2);
  endtask

  task automatic run16(input logic [15:0] v);
    exp_t e;
    step();
    vin16 = v; start16 = 1'b1;
    e.res = v; e.cyc = cyc + 1 + 17;
    q16.push_back(e);
    step();
    start16 = 1'b0;
    wait_idle(16);
  endtask

  logic [7:0] seq [8];
  exp_t eb;
  int   k0;

  initial begin
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    repeat (3) step();
    rst = 1'b0;
    check("reset_sample", 32'(sample8), 0);
    check("reset_dac", 32'(dac8), 0);
    check("reset_result", 32'(res8), 0);
    check("reset_busy", 32'(busy8), 0);

    // Nominal conversion with cycle-by-cycle trial codes
    launch8(8'hA5, 1'b1);
    check("nom_sample_c1", 32'(sample8), 1);
    check("nom_busy", 32'(busy8), 1);
    step();
    check("nom_sample_c2", 32'(sample8), 1);
    step();
    check("nom_sample_off", 32'(sample8), 0);
    check("nom_dac0", 32'(dac8), 32'(seq[0]));
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("nom_dac%0d", i), 32'(dac8), 32'(seq[i]));
    end
    step();
    check("nom_dac_clear", 32'(dac8), 0);
    check("nom_busy_end", 32'(busy8), 0);
    step();
    check("nom_valid_drop", 32'(valid8), 0);

    run8(8'h00);
    run8(8'hFF);

    // Start without enable is ignored
    ena8 = 1'b0;
    start8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gate_busy", 32'(busy8), 0);
      check("gate_sample", 32'(sample8), 0);
    end
    start8 = 1'b0;
    ena8 = 1'b1;

    // Abort after the third bit edge keeps the previous result
    run8(8'hA5);
    launch8(8'h33, 1'b0);
    repeat (5) step();
    ena8 = 1'b0;
    step();
    check("abort_busy", 32'(busy8), 0);
    check("abort_dac", 32'(dac8), 0);
    check("abort_sample", 32'(sample8), 0);
    check("abort_result", 32'(res8), 32'hA5);
    repeat (3) step();
    ena8 = 1'b1;

    // Second start during CONVERT is ignored
    launch8(8'h6E, 1'b1);
    repeat (4) step();
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait_idle(8);
    repeat (3) step();
    check("ignore_busy_after", 32'(busy8), 0);

    // Reset mid-CONVERT, then a normal conversion
    launch8(8'h91, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_sample", 32'(sample8), 0);
    check("rst_dac", 32'(dac8), 0);
    check("rst_result", 32'(res8), 0);
    check("rst_valid", 32'(valid8), 0);
    check("rst_busy", 32'(busy8), 0);
    run8(8'h3C);

    // Back-to-back: start held high, valid every 11 cycles
    step();
    vin8 = 8'h5A;
    start8 = 1'b1;
    k0 = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      eb.res = 16'h005A;
      eb.cyc = k0 + 10 + 11 * j;
      q8.push_back(eb);
    end
    while (cyc < k0 + 22) step();
    start8 = 1'b0;
    wait_idle(8);

    // Parameter sweep
    run2(2'd0);
    run2(2'd3);
    run2(2'($urandom_range(0, 3)));
    run2(2'($urandom_range(0, 3)));
    run16(16'h0000);
    run16(16'hFFFF);
    run16(16'($urandom));
    run16(16'($urandom));

    repeat (5) step();
    check("pending8", q8.size(), 0);
    check("pending2", q2.size(), 0);
    check("pending16", q16.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
